// File: rtl/fpu_pkg.sv
// Shared FPU definitions: stage codes, op encodings and format constant helpers.
package fpu_pkg;

    typedef enum logic [3:0] {
        STATE_NORMAL = 4'd0,
        STATE_MUL    = 4'd2,
        STATE_ALIGN  = 4'd4,
        STATE_PUT_Z  = 4'd11
    } fpu_state_e;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_MUL  = 2'd2,
        OP_RSVD = 2'd3
    } fpu_op_e;

    // Outcome of special-case screening besides the packed result itself.
    typedef struct packed {
        fpu_state_e state;
        logic       invalid;
    } fpu_decision_t;

    function automatic int e_bias(input int unsigned exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int e_inf(input int unsigned exp_w);
        return e_bias(exp_w) + 1;
    endfunction

    function automatic int e_zero(input int unsigned exp_w);
        return -e_bias(exp_w);
    endfunction

    // Canonical quiet NaN: sign set, exponent all ones, only fraction MSB set.
    function automatic logic [63:0] qnan_bits(input int unsigned exp_w, input int unsigned man_w);
        logic [63:0] one;
        one = 64'd1;
        return (one << (exp_w + man_w)) | (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fpu_operand_class.sv
// Combinational classification of one unpacked operand (NaN / Inf / zero / subnormal).
module fpu_operand_class
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic signed [EXP_W+1:0] e,
    input  logic        [MAN_W+3:0] m,
    output logic                    is_nan_c,
    output logic                    is_inf_c,
    output logic                    is_zero_c,
    output logic                    is_sub_c
);

    localparam int unsigned EW = EXP_W + 2;
    localparam logic [EW-1:0] E_INF_V  = EW'(e_inf(EXP_W));
    localparam logic [EW-1:0] E_ZERO_V = EW'(e_zero(EXP_W));

    logic m_nz;
    logic e_max;
    logic e_min;

    assign m_nz  = |m;
    assign e_max = (e == E_INF_V);
    assign e_min = (e == E_ZERO_V);

    assign is_nan_c  = e_max & m_nz;
    assign is_inf_c  = e_max & ~m_nz;
    assign is_zero_c = e_min & ~m_nz;
    assign is_sub_c  = e_min & m_nz;

endmodule

// File: rtl/fpu_special_stage.sv
// Special-case screening stage for add/sub/mul with valid/ready flow control.
// FPU_SUBNORM_EN: keep subnormal operands on the normal path instead of flushing them to zero.
module fpu_special_stage
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              op,
    input  logic signed [EXP_W+1:0] a_e,
    input  logic signed [EXP_W+1:0] b_e,
    input  logic [MAN_W+3:0]        a_m,
    input  logic [MAN_W+3:0]        b_m,
    input  logic                    a_s,
    input  logic                    b_s,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MAN_W:0]    z,
    output logic [3:0]              next_state,
    output logic                    flag_invalid,
    input  logic                    flag_clr,
    output logic [CNT_W-1:0]        special_cnt
);

    localparam int unsigned W = EXP_W + MAN_W + 1;
    localparam logic [W-1:0]     QNAN   = W'(qnan_bits(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0] BIAS_V = EXP_W'(e_bias(EXP_W));
`ifdef FPU_SUBNORM_EN
    localparam logic SUBNORM_EN = 1'b1;
`else
    localparam logic SUBNORM_EN = 1'b0;
`endif

    logic a_nan_c, a_inf_c, a_zero_c, a_sub_c;
    logic b_nan_c, b_inf_c, b_zero_c, b_sub_c;
    logic a_zero, b_zero, eb_s, ms, in_fire;
    logic [W-1:0]  res_z;
    fpu_decision_t res;
    fpu_state_e    state_q;

    fpu_operand_class #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_a (
        .e(a_e), .m(a_m),
        .is_nan_c(a_nan_c), .is_inf_c(a_inf_c), .is_zero_c(a_zero_c), .is_sub_c(a_sub_c)
    );

    fpu_operand_class #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_b (
        .e(b_e), .m(b_m),
        .is_nan_c(b_nan_c), .is_inf_c(b_inf_c), .is_zero_c(b_zero_c), .is_sub_c(b_sub_c)
    );

    // Without subnormal support a subnormal counts as a signed zero.
    assign a_zero = a_zero_c | (a_sub_c & ~SUBNORM_EN);
    assign b_zero = b_zero_c | (b_sub_c & ~SUBNORM_EN);
    assign eb_s   = b_s ^ (op == OP_SUB);
    assign ms     = a_s ^ b_s;

    assign in_ready = ~out_valid | out_ready;
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        res_z       = '0;
        res.state   = STATE_PUT_Z;
        res.invalid = 1'b0;
        if (op == OP_MUL) begin
            if (a_nan_c | b_nan_c) begin
                res_z = QNAN;
            end else if ((a_inf_c & b_zero) | (b_inf_c & a_zero)) begin
                res_z       = QNAN;
                res.invalid = 1'b1;
            end else if (a_inf_c | b_inf_c) begin
                res_z = {ms, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (a_zero | b_zero) begin
                res_z = {ms, {(W-1){1'b0}}};
            end else begin
                res.state = STATE_MUL;
            end
        end else begin
            if (a_nan_c | b_nan_c) begin
                res_z = QNAN;
            end else if (a_inf_c) begin
                if (b_inf_c & (a_s != eb_s)) begin
                    res_z       = QNAN;
                    res.invalid = 1'b1;
                end else begin
                    res_z = {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end
            end else if (b_inf_c) begin
                res_z = {eb_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (a_zero & b_zero) begin
                res_z = {a_s & eb_s, {(W-1){1'b0}}};
            end else if (a_zero) begin
                res_z = {eb_s, b_e[EXP_W-1:0] + BIAS_V, b_m[MAN_W+2:3]};
            end else if (b_zero) begin
                res_z = {a_s, a_e[EXP_W-1:0] + BIAS_V, a_m[MAN_W+2:3]};
            end else begin
                res.state = STATE_ALIGN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            z            <= '0;
            state_q      <= STATE_NORMAL;
            flag_invalid <= 1'b0;
            special_cnt  <= '0;
        end else begin
            if (in_fire) begin
                out_valid <= 1'b1;
                z         <= res_z;
                state_q   <= res.state;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (flag_clr) begin
                flag_invalid <= 1'b0;
            end else if (in_fire & res.invalid) begin
                flag_invalid <= 1'b1;
            end
            if (out_valid & out_ready & (state_q == STATE_PUT_Z) & (special_cnt != '1)) begin
                special_cnt <= special_cnt + CNT_W'(1);
            end
        end
    end

    assign next_state = state_q;

endmodule

// File: tb/tb_fpu_special_stage.sv
// Directed self-checking bench for fpu_special_stage (single precision, 4-bit counter).
module tb_fpu_special_stage;

    localparam int unsigned CW = 4;
    localparam logic [9:0]  E_INF  = 10'd128;
    localparam logic [9:0]  E_ZERO = 10'h381;
    localparam logic [26:0] ONE_M  = 27'h4000000;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, a_s, b_s, out_valid, out_ready, flag_invalid, flag_clr;
    logic [1:0]    op;
    logic [9:0]    a_e, b_e;
    logic [26:0]   a_m, b_m;
    logic [31:0]   z;
    logic [3:0]    next_state;
    logic [CW-1:0] special_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    fpu_special_stage #(.EXP_W(8), .MAN_W(23), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a_e(a_e), .b_e(b_e), .a_m(a_m), .b_m(b_m), .a_s(a_s), .b_s(b_s),
        .out_valid(out_valid), .out_ready(out_ready), .z(z), .next_state(next_state),
        .flag_invalid(flag_invalid), .flag_clr(flag_clr), .special_cnt(special_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bump_cnt();
        if (exp_cnt < 15) exp_cnt++;
    endtask

    task automatic set_ops(input logic [1:0] o, input logic [9:0] ae, input logic [26:0] am, input logic as_,
                           input logic [9:0] be, input logic [26:0] bm, input logic bs_);
        op = o; a_e = ae; a_m = am; a_s = as_; b_e = be; b_m = bm; b_s = bs_;
    endtask

    // One transfer with out_ready high, then an idle cycle so the result drains.
    task automatic send(input string tag, input logic [1:0] o, input logic [9:0] ae, input logic [26:0] am,
                        input logic as_, input logic [9:0] be, input logic [26:0] bm, input logic bs_,
                        input logic [31:0] exp_z, input logic [3:0] exp_ns, input logic exp_flag);
        set_ops(o, ae, am, as_, be, bm, bs_);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".z"}, 64'(z), 64'(exp_z));
        check({tag, ".ns"}, 64'(next_state), 64'(exp_ns));
        check({tag, ".flag"}, 64'(flag_invalid), 64'(exp_flag));
        @(posedge clk); #1;
        if (exp_ns == 4'd11) bump_cnt();
        check({tag, ".cnt"}, 64'(special_cnt), 64'(exp_cnt));
        check({tag, ".drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;
        set_ops(2'd0, 10'd0, 27'd0, 1'b0, 10'd0, 27'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.z", 64'(z), 64'd0);
        check("rst.ns", 64'(next_state), 64'd0);
        check("rst.flag", 64'(flag_invalid), 64'd0);
        check("rst.cnt", 64'(special_cnt), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        send("add_nan", 2'd0, E_INF, 27'd1, 1'b0, 10'd0, ONE_M, 1'b0, 32'hFFC00000, 4'd11, 1'b0);
        send("add_inf_inf", 2'd0, E_INF, 27'd0, 1'b0, E_INF, 27'd0, 1'b1, 32'hFFC00000, 4'd11, 1'b1);
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        check("flag_clr", 64'(flag_invalid), 64'd0);
        send("add_inf_same", 2'd0, E_INF, 27'd0, 1'b0, E_INF, 27'd0, 1'b0, 32'h7F800000, 4'd11, 1'b0);
        send("sub_inf_inf", 2'd1, E_INF, 27'd0, 1'b1, E_INF, 27'd0, 1'b0, 32'hFF800000, 4'd11, 1'b0);
        send("sub_zero_b", 2'd1, E_ZERO, 27'd0, 1'b0, 10'd0, ONE_M, 1'b1, 32'h3F800000, 4'd11, 1'b0);
        send("sub_b_inf", 2'd1, 10'd3, ONE_M, 1'b0, E_INF, 27'd0, 1'b0, 32'hFF800000, 4'd11, 1'b0);
        send("add_b_zero", 2'd0, 10'd1, 27'h6000000, 1'b0, E_ZERO, 27'd0, 1'b1, 32'h40400000, 4'd11, 1'b0);
        send("add_zz_neg", 2'd0, E_ZERO, 27'd0, 1'b1, E_ZERO, 27'd0, 1'b1, 32'h80000000, 4'd11, 1'b0);
        send("add_zz_mix", 2'd0, E_ZERO, 27'd0, 1'b1, E_ZERO, 27'd0, 1'b0, 32'h00000000, 4'd11, 1'b0);
        send("sub_zz", 2'd1, E_ZERO, 27'd0, 1'b1, E_ZERO, 27'd0, 1'b0, 32'h80000000, 4'd11, 1'b0);
        send("add_normal", 2'd0, 10'd1, ONE_M, 1'b0, 10'd2, ONE_M, 1'b1, 32'h0, 4'd4, 1'b0);
        send("rsvd_as_add", 2'd3, E_ZERO, 27'd0, 1'b0, 10'd0, ONE_M, 1'b0, 32'h3F800000, 4'd11, 1'b0);
        send("mul_inf_zero", 2'd2, E_INF, 27'd0, 1'b0, E_ZERO, 27'd0, 1'b1, 32'hFFC00000, 4'd11, 1'b1);
        flag_clr = 1'b1;
        send("mul_clr_prio", 2'd2, E_ZERO, 27'd0, 1'b0, E_INF, 27'd0, 1'b0, 32'hFFC00000, 4'd11, 1'b0);
        flag_clr = 1'b0;
        send("mul_normal", 2'd2, 10'd1, ONE_M, 1'b0, 10'd2, ONE_M, 1'b0, 32'h0, 4'd2, 1'b0);
        send("mul_inf_x", 2'd2, E_INF, 27'd0, 1'b1, 10'd5, ONE_M, 1'b0, 32'hFF800000, 4'd11, 1'b0);
        send("mul_zero_x", 2'd2, E_ZERO, 27'd0, 1'b1, 10'd5, ONE_M, 1'b0, 32'h80000000, 4'd11, 1'b0);
        send("mul_nan", 2'd2, 10'd5, ONE_M, 1'b0, E_INF, 27'h100, 1'b0, 32'hFFC00000, 4'd11, 1'b0);
`ifdef FPU_SUBNORM_EN
        send("subnorm_a", 2'd0, E_ZERO, 27'h8, 1'b0, 10'd0, ONE_M, 1'b0, 32'h0, 4'd4, 1'b0);
`else
        send("subnorm_a", 2'd0, E_ZERO, 27'h8, 1'b0, 10'd0, ONE_M, 1'b0, 32'h3F800000, 4'd11, 1'b0);
`endif

        // Backpressure: result A is held while B waits at the input.
        out_ready = 1'b0;
        set_ops(2'd0, E_INF, 27'd1, 1'b0, 10'd0, ONE_M, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("bp.first", 64'(z), 64'hFFC00000);
        set_ops(2'd0, E_ZERO, 27'd0, 1'b0, 10'd0, ONE_M, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp.in_ready", 64'(in_ready), 64'd0);
            check("bp.hold_z", 64'(z), 64'hFFC00000);
            check("bp.hold_valid", 64'(out_valid), 64'd1);
            @(posedge clk); #1;
        end
        check("bp.no_count", 64'(special_cnt), 64'(exp_cnt));
        out_ready = 1'b1;
        #1;
        check("bp.ready_rise", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        bump_cnt();
        check("bp.second", 64'(z), 64'h3F800000);
        check("bp.cnt1", 64'(special_cnt), 64'(exp_cnt));
        @(posedge clk); #1;
        bump_cnt();
        check("bp.cnt2", 64'(special_cnt), 64'(exp_cnt));
        check("bp.drain", 64'(out_valid), 64'd0);

        // Saturation: specials keep arriving after the counter is full.
        for (int i = 0; i < 3; i++)
            send("sat", 2'd0, E_INF, 27'd1, 1'b0, 10'd0, ONE_M, 1'b0, 32'hFFC00000, 4'd11, 1'b0);
        check("sat.value", 64'(special_cnt), 64'd15);

        // Reset while a result is held discards it.
        out_ready = 1'b0;
        set_ops(2'd2, E_INF, 27'd0, 1'b0, 10'd1, ONE_M, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid.held", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid.valid", 64'(out_valid), 64'd0);
        check("mid.z", 64'(z), 64'd0);
        check("mid.ns", 64'(next_state), 64'd0);
        check("mid.cnt", 64'(special_cnt), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("mid.after", 64'(special_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
